// File: rtl/bit_serial_alu.sv
// Bit-serial ALU: one 1-bit slice stepped LSB-first over WIDTH cycles, plus a compare cycle for op 3.
// done_o rises WIDTH (ops 0-2) or WIDTH+1 (op 3) edges after accept; start_i is ignored while busy_o is high.
module bit_serial_alu #(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [WIDTH-1:0] src1_i,
  input  logic [WIDTH-1:0] src2_i,
  input  logic [3:0]       ALU_control_i,
  input  logic [2:0]       bonus_control_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] result_o,
  output logic             zero_o,
  output logic             cout_o,
  output logic             overflow_o
);

  localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, CMP, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] sum_sr;
  logic             a_inv;
  logic             b_inv;
  logic [1:0]       op;
  logic [2:0]       comp;
  logic             carry;
  logic [IW-1:0]    idx;
  logic             cin_msb;
  logic             cout_msb;

  logic             slice_a;
  logic             slice_b;
  logic             slice_res;
  logic             slice_cout;
  logic [WIDTH-1:0] sum_next;
  logic             last_bit;
  logic             less;
  logic             equal;
  logic             cmp_bit;

  // One ALU slice; op 3 runs the adder so the compare cycle can inspect the difference.
  always_comb begin
    slice_a    = a_sr[0] ^ a_inv;
    slice_b    = b_sr[0] ^ b_inv;
    slice_cout = (slice_a & slice_b) | (carry & (slice_a ^ slice_b));
    slice_res  = 1'b0;
    case (op)
      2'd0:    slice_res = slice_a & slice_b;
      2'd1:    slice_res = slice_a | slice_b;
      default: slice_res = slice_a ^ slice_b ^ carry;
    endcase
    sum_next = {slice_res, sum_sr[WIDTH-1:1]};
    last_bit = (idx == LAST_IDX);
  end

  // Signed less-than corrects the sign bit of A-B by the overflow flag.
  always_comb begin
    less    = sum_sr[WIDTH-1] ^ (cin_msb ^ cout_msb);
    equal   = (sum_sr == '0);
    cmp_bit = 1'b0;
    case (comp)
      3'b000:  cmp_bit = less;
      3'b001:  cmp_bit = ~less & ~equal;
      3'b010:  cmp_bit = less | equal;
      3'b011:  cmp_bit = ~less;
      3'b110:  cmp_bit = equal;
      3'b100:  cmp_bit = ~equal;
      default: cmp_bit = 1'b0;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state      <= IDLE;
      a_sr       <= '0;
      b_sr       <= '0;
      sum_sr     <= '0;
      a_inv      <= 1'b0;
      b_inv      <= 1'b0;
      op         <= 2'd0;
      comp       <= 3'd0;
      carry      <= 1'b0;
      idx        <= '0;
      cin_msb    <= 1'b0;
      cout_msb   <= 1'b0;
      busy_o     <= 1'b0;
      done_o     <= 1'b0;
      result_o   <= '0;
      zero_o     <= 1'b0;
      cout_o     <= 1'b0;
      overflow_o <= 1'b0;
    end else begin
      done_o <= 1'b0;
      case (state)
        IDLE, DONE: begin
          state  <= IDLE;
          busy_o <= 1'b0;
          if (start_i) begin
            a_sr   <= src1_i;
            b_sr   <= src2_i;
            sum_sr <= '0;
            a_inv  <= ALU_control_i[3];
            b_inv  <= ALU_control_i[2];
            op     <= ALU_control_i[1:0];
            comp   <= bonus_control_i;
            carry  <= ALU_control_i[2];
            idx    <= '0;
            state  <= RUN;
            busy_o <= 1'b1;
          end
        end
        RUN: begin
          a_sr   <= a_sr >> 1;
          b_sr   <= b_sr >> 1;
          sum_sr <= sum_next;
          carry  <= slice_cout;
          idx    <= idx + IW'(1);
          if (last_bit) begin
            cin_msb  <= carry;
            cout_msb <= slice_cout;
            if (op == 2'd3) begin
              state <= CMP;
            end else begin
              state      <= DONE;
              busy_o     <= 1'b0;
              done_o     <= 1'b1;
              result_o   <= sum_next;
              zero_o     <= (sum_next == '0);
              cout_o     <= (op == 2'd2) ? slice_cout : 1'b0;
              overflow_o <= (op == 2'd2) ? (carry ^ slice_cout) : 1'b0;
            end
          end
        end
        CMP: begin
          state      <= DONE;
          busy_o     <= 1'b0;
          done_o     <= 1'b1;
          result_o   <= {{(WIDTH-1){1'b0}}, cmp_bit};
          zero_o     <= ~cmp_bit;
          cout_o     <= 1'b0;
          overflow_o <= 1'b0;
        end
        default: begin
          state  <= IDLE;
          busy_o <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bit_serial_alu.sv
// Scoreboard bench for bit_serial_alu: expectations queued at accept, compared on each done_o pulse.
module tb_bit_serial_alu;

  logic        clk_i;
  logic        rst_i;
  logic        start_i;
  logic [31:0] src1_i;
  logic [31:0] src2_i;
  logic [3:0]  ALU_control_i;
  logic [2:0]  bonus_control_i;
  logic        busy_o;
  logic        done_o;
  logic [31:0] result_o;
  logic        zero_o;
  logic        cout_o;
  logic        overflow_o;

  bit_serial_alu #(.WIDTH(32)) dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .start_i        (start_i),
    .src1_i         (src1_i),
    .src2_i         (src2_i),
    .ALU_control_i  (ALU_control_i),
    .bonus_control_i(bonus_control_i),
    .busy_o         (busy_o),
    .done_o         (done_o),
    .result_o       (result_o),
    .zero_o         (zero_o),
    .cout_o         (cout_o),
    .overflow_o     (overflow_o)
  );

  typedef struct {
    logic [31:0] res;
    logic        z;
    logic        c;
    logic        v;
    int          lat;
    int          acc;
  } exp_t;

  exp_t sb[$];
  int   errs   = 0;
  int   checks = 0;
  int   cyc    = 0;

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;
  always @(posedge clk_i) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic exp_t model(input logic [31:0] a, input logic [31:0] b,
                                 input logic [3:0] ctrl, input logic [2:0] comp);
    exp_t        e;
    logic [31:0] aa;
    logic [31:0] bb;
    logic [32:0] s;
    logic        lt;
    logic        eq;
    logic        r;
    e.res = '0; e.c = 1'b0; e.v = 1'b0; e.lat = 32; e.acc = 0;
    aa = ctrl[3] ? ~a : a;
    bb = ctrl[2] ? ~b : b;
    case (ctrl[1:0])
      2'd0: e.res = aa & bb;
      2'd1: e.res = aa | bb;
      2'd2: begin
        s     = {1'b0, aa} + {1'b0, bb} + {32'd0, ctrl[2]};
        e.res = s[31:0];
        e.c   = s[32];
        e.v   = (aa[31] == bb[31]) && (s[31] != aa[31]);
      end
      default: begin
        lt = $signed(a) < $signed(b);
        eq = (a == b);
        case (comp)
          3'b000:  r = lt;
          3'b001:  r = !lt && !eq;
          3'b010:  r = lt || eq;
          3'b011:  r = !lt;
          3'b110:  r = eq;
          3'b100:  r = !eq;
          default: r = 1'b0;
        endcase
        e.res = {31'd0, r};
        e.lat = 33;
      end
    endcase
    e.z = (e.res == 32'd0);
    return e;
  endfunction

  always @(negedge clk_i) begin
    if (rst_i && done_o) begin
      if (sb.size() == 0) begin
        chk("unexpected_done", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("result", result_o, e.res);
        chk("zero", {31'd0, zero_o}, {31'd0, e.z});
        chk("cout", {31'd0, cout_o}, {31'd0, e.c});
        chk("overflow", {31'd0, overflow_o}, {31'd0, e.v});
        chk("latency", cyc - e.acc, e.lat);
      end
    end
  end

  // Called at a negedge; leaves start_i asserted so the caller decides when to drop it.
  task automatic drive(input logic [31:0] a, input logic [31:0] b,
                       input logic [3:0] ctrl, input logic [2:0] comp, input bit expect_it);
    exp_t e;
    src1_i = a; src2_i = b; ALU_control_i = ctrl; bonus_control_i = comp;
    start_i = 1'b1;
    if (expect_it) begin
      e = model(a, b, ctrl, comp);
      e.acc = cyc + 1;
      sb.push_back(e);
    end
  endtask

  task automatic issue(input logic [31:0] a, input logic [31:0] b,
                       input logic [3:0] ctrl, input logic [2:0] comp);
    int n = 0;
    while (busy_o && n < 100) begin @(negedge clk_i); n++; end
    if (busy_o) chk("busy_timeout", 32'd1, 32'd0);
    drive(a, b, ctrl, comp, 1'b1);
    @(negedge clk_i);
    start_i = 1'b0;
  endtask

  task automatic wait_empty();
    int n = 0;
    while (sb.size() != 0 && n < 200) begin @(negedge clk_i); n++; end
    if (sb.size() != 0) begin
      chk("done_timeout", sb.size(), 32'd0);
      sb.delete();
    end
  endtask

  initial begin
    logic [2:0] comps [8] = '{3'b000, 3'b001, 3'b010, 3'b011, 3'b110, 3'b100, 3'b101, 3'b111};
    rst_i = 1'b0; start_i = 1'b0;
    src1_i = '0; src2_i = '0; ALU_control_i = '0; bonus_control_i = '0;
    repeat (3) @(negedge clk_i);
    chk("rst_busy", {31'd0, busy_o}, 32'd0);
    chk("rst_done", {31'd0, done_o}, 32'd0);
    chk("rst_result", result_o, 32'd0);
    chk("rst_flags", {29'd0, zero_o, cout_o, overflow_o}, 32'd0);
    rst_i = 1'b1;
    @(negedge clk_i);

    issue(32'h7FFF_FFFF, 32'd1, 4'b0010, 3'd0);
    wait_empty();

    // Abort mid-RUN; the monitor flags any done_o since nothing is queued.
    drive(32'h1234_5678, 32'h1111_1111, 4'b0010, 3'd0, 1'b0);
    @(negedge clk_i); start_i = 1'b0;
    repeat (9) @(negedge clk_i);
    chk("midrun_busy", {31'd0, busy_o}, 32'd1);
    rst_i = 1'b0;
    repeat (2) @(negedge clk_i);
    chk("abort_busy", {31'd0, busy_o}, 32'd0);
    chk("abort_done", {31'd0, done_o}, 32'd0);
    chk("abort_result", result_o, 32'd0);
    rst_i = 1'b1;
    repeat (40) @(negedge clk_i);

    issue(32'd5, 32'd5, 4'b0110, 3'd0);
    issue(32'hF0F0_F0F0, 32'hFF00_FF00, 4'b0000, 3'd0);
    issue(32'hF0F0_F0F0, 32'hFF00_FF00, 4'b0001, 3'd0);
    issue(32'hF0F0_F0F0, 32'hFF00_FF00, 4'b1100, 3'd0);
    wait_empty();
    repeat (3) @(negedge clk_i);
    chk("result_hold", result_o, 32'h000F_000F);

    issue(32'hFFFF_FFFF, 32'd1, 4'b0111, 3'b000);
    issue(32'hFFFF_FFFF, 32'd1, 4'b0111, 3'b001);
    issue(32'd7, 32'd7, 4'b0111, 3'b110);
    issue(32'h8000_0000, 32'd1, 4'b0111, 3'b000);
    issue(32'd7, 32'd7, 4'b0111, 3'b010);
    issue(32'd3, 32'd9, 4'b0111, 3'b011);
    issue(32'd3, 32'd9, 4'b0111, 3'b100);
    issue(32'd3, 32'd9, 4'b0111, 3'b111);
    issue(32'hFFFF_FFFF, 32'd1, 4'b0110, 3'd0);
    wait_empty();

    for (int i = 0; i < 12; i++) begin
      logic [31:0] a;
      logic [31:0] b;
      logic [1:0]  op;
      logic [3:0]  ctrl;
      a  = $urandom;
      b  = (i % 3 == 0) ? a : $urandom;
      op = 2'($urandom_range(0, 3));
      ctrl = (op == 2'd3) ? 4'b0111 : {2'($urandom_range(0, 3)), op};
      issue(a, b, ctrl, comps[$urandom_range(0, 7)]);
    end
    wait_empty();

    // start_i held through RUN must yield a single operation.
    drive(32'd100, 32'd23, 4'b0010, 3'd0, 1'b1);
    repeat (20) @(negedge clk_i);
    start_i = 1'b0;
    wait_empty();
    repeat (5) @(negedge clk_i);

    // Second request issued in the DONE cycle is accepted back-to-back.
    issue(32'd40, 32'd2, 4'b0110, 3'd0);
    begin
      int n = 0;
      while (!done_o && n < 60) begin @(negedge clk_i); n++; end
      if (!done_o) chk("b2b_done_timeout", 32'd1, 32'd0);
    end
    drive(32'h8000_0000, 32'h8000_0000, 4'b0010, 3'd0, 1'b1);
    @(negedge clk_i);
    start_i = 1'b0;
    chk("b2b_busy", {31'd0, busy_o}, 32'd1);
    wait_empty();
    repeat (40) @(negedge clk_i);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got cycle %0d expected finish", cyc);
    $fatal(1);
  end

endmodule
